// File: rtl/ps2_pkg.sv
// PS/2 receiver shared definitions: frame states, scan-code prefixes, event layout.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_t;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

  localparam int EV_CODE_W = 8;
  localparam int EV_W      = EV_CODE_W + 2;

  typedef struct packed {
    logic                 brk;
    logic                 ext;
    logic [EV_CODE_W-1:0] code;
  } ev_t;

  // PS/2 uses odd parity across the 8 data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] code, input logic par);
    return ^{code, par};
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Event FIFO with registered head; pointers carry an extra wrap bit.
// Latency: push visible on out_valid the next cycle. Backpressure: push ignored when full unless popping.
module ps2_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;

  logic [WIDTH-1:0] mem [DEPTH];
  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  ptr_t             rd_next;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign out_valid = !empty;
  assign do_pop    = out_valid && out_ready;
  assign do_push   = push && (!full || do_pop);
  assign rd_next   = do_pop ? rd_ptr + ptr_t'(1) : rd_ptr;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Head register: bypass the write when the new head is the slot being written now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      out_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ptr_t'(1);
      rd_ptr <= rd_next;
      if (rd_next == wr_ptr) begin
        if (do_push) out_data <= push_data;
      end else begin
        out_data <= mem[rd_next[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver: sync + glitch filter, frame FSM, prefix decode, event FIFO. Parity check under PS2_PARITY_CHECK_EN.
// Latency: ev_valid 2 cycles after stop-bit edge. Backpressure: event dropped with ovf pulse when FIFO full and not popping.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 5000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ps2clk,
  input  logic            ps2data,
  output logic [EV_W-1:0] ev_data,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic            err_parity,
  output logic            err_frame,
  output logic            ovf
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [1:0] clk_sync;
  logic [1:0] dat_sync;
  logic       sclk;
  logic       sdat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2clk};
      dat_sync <= {dat_sync[0], ps2data};
    end
  end

  assign sclk = clk_sync[1];
  assign sdat = dat_sync[1];

  logic          filt_clk;
  logic          filt_prev;
  logic [FW-1:0] flt_cnt;
  logic          fall;

  // Accept a new ps2clk level only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      flt_cnt   <= '0;
    end else begin
      filt_prev <= filt_clk;
      if (sclk == filt_clk) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_LAST) begin
        filt_clk <= sclk;
        flt_cnt  <= '0;
      end else begin
        flt_cnt <= flt_cnt + FW'(1);
      end
    end
  end

  assign fall = filt_prev && !filt_clk;

  frame_state_t  state, state_d;
  logic [2:0]    bit_cnt, bit_cnt_d;
  logic [7:0]    shreg, shreg_d;
  logic [TW-1:0] tmo_cnt, tmo_d;
  logic          byte_ok_d, frame_err_d, par_err_d;
  logic          byte_ok, frame_err_q, par_err_q;
  logic          par_bad;

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_bit <= 1'b0;
    else if (fall && state == ST_PARITY) par_bit <= sdat;
  end

  assign par_bad = !odd_parity_ok(shreg, par_bit);
`else
  assign par_bad = 1'b0;
`endif

  always_comb begin
    state_d     = state;
    bit_cnt_d   = bit_cnt;
    shreg_d     = shreg;
    tmo_d       = tmo_cnt;
    byte_ok_d   = 1'b0;
    frame_err_d = 1'b0;
    par_err_d   = 1'b0;
    if (state == ST_IDLE) begin
      tmo_d = '0;
      if (fall && !sdat) begin
        state_d   = ST_DATA;
        bit_cnt_d = '0;
      end
    end else if (fall) begin
      tmo_d = '0;
      case (state)
        ST_DATA: begin
          shreg_d   = {sdat, shreg[7:1]};
          bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: state_d = ST_STOP;
        default: begin
          state_d = ST_IDLE;
          if (!sdat)        frame_err_d = 1'b1;
          else if (par_bad) par_err_d   = 1'b1;
          else              byte_ok_d   = 1'b1;
        end
      endcase
    end else if (tmo_cnt == TMO_LAST) begin
      state_d     = ST_IDLE;
      tmo_d       = '0;
      frame_err_d = 1'b1;
    end else begin
      tmo_d = tmo_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      tmo_cnt     <= '0;
      byte_ok     <= 1'b0;
      frame_err_q <= 1'b0;
      par_err_q   <= 1'b0;
    end else begin
      state       <= state_d;
      bit_cnt     <= bit_cnt_d;
      shreg       <= shreg_d;
      tmo_cnt     <= tmo_d;
      byte_ok     <= byte_ok_d;
      frame_err_q <= frame_err_d;
      par_err_q   <= par_err_d;
    end
  end

  logic ext_flag, brk_flag;
  logic is_ext, is_brk;
  logic push;
  logic fifo_full;
  ev_t  push_ev;

  // shreg is stable in the cycle after the stop edge since the FSM is back in IDLE.
  assign is_ext  = (shreg == PS2_EXT_PREFIX);
  assign is_brk  = (shreg == PS2_BRK_PREFIX);
  assign push    = byte_ok && !is_ext && !is_brk;
  assign push_ev = {brk_flag, ext_flag, shreg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
    end else if (frame_err_q || par_err_q) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
    end else if (byte_ok) begin
      if (is_ext) begin
        ext_flag <= 1'b1;
      end else if (is_brk) begin
        brk_flag <= 1'b1;
      end else begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end
    end
  end

  ps2_event_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(EV_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(push_ev),
    .full     (fifo_full),
    .out_data (ev_data),
    .out_valid(ev_valid),
    .out_ready(ev_ready)
  );

  assign ovf        = push && fifo_full && !(ev_valid && ev_ready);
  assign err_frame  = frame_err_q;
  assign err_parity = par_err_q;

endmodule
